npi_pi_arbiter: RTL and testbench

NPI_PI_ARBITER -- requirements
Module: npi_pi_arbiter

---
 rtl/npi_pi_arbiter.sv | 126 ++++++++++++
 tb/tb_npi_pi_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npi_pi_arbiter.sv
// rtl/npi_pi_arbiter.sv - round-robin arbiter sharing one NPI port among slow-clock DMA channels
module npi_pi_arbiter #(
    parameter int C_NUM_CH = 2,
    parameter int C_RATIO  = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [C_NUM_CH-1:0]     Ch_AddrReq,
    output logic [C_NUM_CH-1:0]     Ch_AddrAck,
    input  logic [C_NUM_CH-1:0]     Ch_RNW,
    input  logic [32*C_NUM_CH-1:0]  Ch_Addr,
    input  logic [4*C_NUM_CH-1:0]   Ch_Size,
    input  logic [C_NUM_CH-1:0]     Ch_RdFIFO_Pop,
    input  logic [C_NUM_CH-1:0]     Ch_WrFIFO_Push,
    output logic                    PIM_AddrReq,
    input  logic                    PIM_AddrAck,
    output logic                    PIM_RNW,
    output logic [31:0]             PIM_Addr,
    output logic [3:0]              PIM_Size,
    output logic                    PIM_RdFIFO_Pop,
    output logic                    PIM_WrFIFO_Push,
    output logic [C_NUM_CH-1:0]     Owner,
    output logic                    pi_enable,
    output logic                    Err
);
    localparam int              CW         = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
    localparam logic [1:0]      LAST_PHASE = 2'(C_RATIO - 1);
    localparam logic [CW-1:0]   LAST_CH    = CW'(C_NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t         state;
    logic [1:0]     phase;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  owner_idx;
    logic [CW-1:0]  gnt_idx;
    logic           gnt_found;
    logic           phase0;
    logic           stray;

    // Phase within the slow-clock period; the last phase is the slow-domain sample cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase <= '0;
        end else if (phase == LAST_PHASE) begin
            phase <= '0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    assign pi_enable = (phase == LAST_PHASE);
    assign phase0    = (phase == 2'd0);

    // Round-robin search starting at rr_ptr; the descending loop lets the nearest requester win.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = C_NUM_CH - 1; k >= 0; k--) begin
            if (Ch_AddrReq[(int'(rr_ptr) + k) % C_NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_idx   = CW'((int'(rr_ptr) + k) % C_NUM_CH);
            end
        end
    end

    // Arbiter FSM; the granted channel's command is captured and held until the next grant.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner_idx   <= '0;
            Owner       <= C_NUM_CH'(1);
            PIM_AddrReq <= 1'b0;
            PIM_RNW     <= 1'b0;
            PIM_Addr    <= '0;
            PIM_Size    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pi_enable && gnt_found) begin
                        state       <= REQ;
                        PIM_AddrReq <= 1'b1;
                        owner_idx   <= gnt_idx;
                        Owner       <= C_NUM_CH'(1) << gnt_idx;
                        PIM_RNW     <= Ch_RNW[gnt_idx];
                        PIM_Addr    <= Ch_Addr[32*gnt_idx +: 32];
                        PIM_Size    <= Ch_Size[4*gnt_idx +: 4];
                        rr_ptr      <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
                    end
                end
                REQ: begin
                    if (PIM_AddrAck) begin
                        state       <= HOLD;
                        PIM_AddrReq <= 1'b0;
                    end
                end
                HOLD: begin
                    // Stretch the ack until the slow domain has had a sample cycle to see it.
                    if (pi_enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Ch_AddrAck = (((state == REQ) && PIM_AddrAck) || (state == HOLD)) ? Owner : '0;

    // Slow-domain levels are turned into single NPI-clock strobes, owner only.
    assign PIM_WrFIFO_Push = Ch_WrFIFO_Push[owner_idx] & phase0 & ~sys_rst;
    assign PIM_RdFIFO_Pop  = Ch_RdFIFO_Pop[owner_idx] & pi_enable & ~sys_rst;

    assign stray = (phase0 && (|(Ch_WrFIFO_Push & ~Owner))) ||
                   (pi_enable && (|(Ch_RdFIFO_Pop & ~Owner)));

    // Sticky error on any qualified push or pop from a channel that does not own the data path.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            Err <= 1'b0;
        end else if (stray) begin
            Err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_npi_pi_arbiter.sv
// tb/tb_npi_pi_arbiter.sv - self-checking bench for npi_pi_arbiter
module tb_npi_pi_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rst;
    logic [1:0]  req, rnw, rd_pop, wr_push;
    logic [63:0] addr;
    logic [7:0]  size;
    logic        pim_ack;

    logic [1:0]  a_ch_ack, a_owner, b_ch_ack, b_owner, c_ch_ack, c_owner;
    logic        a_addr_req, a_rnw, a_rd_pop, a_wr_push, a_pi_en, a_err;
    logic        b_addr_req, b_rnw, b_rd_pop, b_wr_push, b_pi_en, b_err;
    logic        c_addr_req, c_rnw, c_rd_pop, c_wr_push, c_pi_en, c_err;
    logic [31:0] a_addr, b_addr, c_addr;
    logic [3:0]  a_size, b_size, c_size;

    npi_pi_arbiter #(.C_NUM_CH(2), .C_RATIO(2)) dut_a (
        .sys_clk(clk), .sys_rst(sys_rst), .Ch_AddrReq(req), .Ch_AddrAck(a_ch_ack),
        .Ch_RNW(rnw), .Ch_Addr(addr), .Ch_Size(size), .Ch_RdFIFO_Pop(rd_pop),
        .Ch_WrFIFO_Push(wr_push), .PIM_AddrReq(a_addr_req), .PIM_AddrAck(pim_ack),
        .PIM_RNW(a_rnw), .PIM_Addr(a_addr), .PIM_Size(a_size), .PIM_RdFIFO_Pop(a_rd_pop),
        .PIM_WrFIFO_Push(a_wr_push), .Owner(a_owner), .pi_enable(a_pi_en), .Err(a_err));

    npi_pi_arbiter #(.C_NUM_CH(2), .C_RATIO(4)) dut_b (
        .sys_clk(clk), .sys_rst(sys_rst), .Ch_AddrReq(req), .Ch_AddrAck(b_ch_ack),
        .Ch_RNW(rnw), .Ch_Addr(addr), .Ch_Size(size), .Ch_RdFIFO_Pop(rd_pop),
        .Ch_WrFIFO_Push(wr_push), .PIM_AddrReq(b_addr_req), .PIM_AddrAck(pim_ack),
        .PIM_RNW(b_rnw), .PIM_Addr(b_addr), .PIM_Size(b_size), .PIM_RdFIFO_Pop(b_rd_pop),
        .PIM_WrFIFO_Push(b_wr_push), .Owner(b_owner), .pi_enable(b_pi_en), .Err(b_err));

    npi_pi_arbiter #(.C_NUM_CH(2), .C_RATIO(1)) dut_c (
        .sys_clk(clk), .sys_rst(sys_rst), .Ch_AddrReq(req), .Ch_AddrAck(c_ch_ack),
        .Ch_RNW(rnw), .Ch_Addr(addr), .Ch_Size(size), .Ch_RdFIFO_Pop(rd_pop),
        .Ch_WrFIFO_Push(wr_push), .PIM_AddrReq(c_addr_req), .PIM_AddrAck(pim_ack),
        .PIM_RNW(c_rnw), .PIM_Addr(c_addr), .PIM_Size(c_size), .PIM_RdFIFO_Pop(c_rd_pop),
        .PIM_WrFIFO_Push(c_wr_push), .Owner(c_owner), .pi_enable(c_pi_en), .Err(c_err));

    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        logic [3:0]  size;
        logic [1:0]  owner;
    } grant_t;

    typedef struct {
        logic [1:0] rd;
        logic [1:0] wr;
        logic       pop;
        logic       push;
        logic       err;
    } vec_t;

    grant_t sb_q[$];
    vec_t   vt[8];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc;
    int     pulses;
    int     n;
    logic   done;

    // Reference slow-clock phase: cycles since reset release.
    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic pi_model(input int r);
        return (cyc % r) == (r - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] a, input logic r, input logic [3:0] s, input logic [1:0] o);
        grant_t g;
        g.addr = a; g.rnw = r; g.size = s; g.owner = o;
        sb_q.push_back(g);
    endtask

    task automatic wait_grant(input string name);
        grant_t e;
        int k;
        k = 0;
        while (a_addr_req !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            check({name, "_timeout"}, {31'd0, a_addr_req}, 32'd1);
        end else if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected: grant to owner 0x%0h with nothing expected", name, a_owner);
        end else begin
            e = sb_q.pop_front();
            check({name, "_addr"},  a_addr, e.addr);
            check({name, "_rnw"},   {31'd0, a_rnw}, {31'd0, e.rnw});
            check({name, "_size"},  {28'd0, a_size}, {28'd0, e.size});
            check({name, "_owner"}, {30'd0, a_owner}, {30'd0, e.owner});
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        sys_rst = 1'b1; req = '0; rd_pop = '0; wr_push = '0; pim_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 sys_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Owner is ch1 on dut_c when this table runs.
        vt[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vt[1] = '{2'b10, 2'b00, 1'b1, 1'b0, 1'b0};
        vt[2] = '{2'b00, 2'b10, 1'b0, 1'b1, 1'b0};
        vt[3] = '{2'b10, 2'b10, 1'b1, 1'b1, 1'b0};
        vt[4] = '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        vt[5] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
        vt[6] = '{2'b11, 2'b01, 1'b1, 1'b0, 1'b1};
        vt[7] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b1};

        sys_rst = 1'b1; req = '0; rnw = 2'b11; rd_pop = 2'b11; wr_push = 2'b11;
        addr = {32'hFFFF_FFFF, 32'hFFFF_FFFF}; size = 8'hFF; pim_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr_req", {31'd0, a_addr_req}, 32'd0);
        check("rst_ch_ack", {30'd0, a_ch_ack}, 32'd0);
        check("rst_rnw", {31'd0, a_rnw}, 32'd0);
        check("rst_addr", a_addr, 32'd0);
        check("rst_size", {28'd0, a_size}, 32'd0);
        check("rst_rd_pop", {31'd0, a_rd_pop}, 32'd0);
        check("rst_wr_push", {31'd0, a_wr_push}, 32'd0);
        check("rst_err", {31'd0, a_err}, 32'd0);
        check("rst_owner", {30'd0, a_owner}, 32'd1);
        check("rst_pi_en_r2", {31'd0, a_pi_en}, 32'd0);
        check("rst_pi_en_r1", {31'd0, c_pi_en}, 32'd1);
        check("rst_rd_pop_r1", {31'd0, c_rd_pop}, 32'd0);

        // First pi_enable after release
        @(posedge clk); #1;
        sys_rst = 1'b0; rd_pop = '0; wr_push = '0; pim_ack = 1'b0; rnw = '0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); @(negedge clk);
            check("rel_pi_en_r4", {31'd0, b_pi_en}, {31'd0, pi_model(4)});
            check("rel_pi_en_r2", {31'd0, a_pi_en}, {31'd0, pi_model(2)});
        end

        // S1: single read on ch0, ack 3 cycles after the request
        do_reset();
        sb_push(32'h1000, 1'b1, 4'h3, 2'b01);
        req = 2'b01; rnw = 2'b01; addr[31:0] = 32'h1000; size[3:0] = 4'h3;
        wait_grant("s1");
        @(posedge clk); #1; req = '0;
        @(negedge clk);
        check("s1_wait1_ack", {30'd0, a_ch_ack}, 32'd0);
        check("s1_wait1_req", {31'd0, a_addr_req}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("s1_wait2_ack", {30'd0, a_ch_ack}, 32'd0);
        @(posedge clk); #1; pim_ack = 1'b1;
        @(negedge clk);
        check("s1_ack_cycle", {30'd0, a_ch_ack}, 32'd1);
        check("s1_addr", a_addr, 32'h1000);
        check("s1_rnw", {31'd0, a_rnw}, 32'd1);
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clk); #1; pim_ack = 1'b0;
            @(negedge clk);
            check("s1_hold_ack", {30'd0, a_ch_ack}, 32'd1);
            check("s1_no_rereq", {31'd0, a_addr_req}, 32'd0);
            if (pi_model(2)) done = 1'b1;
        end
        check("s1_hold_exit", {31'd0, done}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("s1_ack_clear", {30'd0, a_ch_ack}, 32'd0);
            check("s1_no_rereq_after", {31'd0, a_addr_req}, 32'd0);
        end

        // S2: both channels request continuously, grants alternate
        do_reset();
        addr = {32'hB000_0004, 32'hA000_0000}; rnw = 2'b10; size = {4'h5, 4'h7};
        for (int g = 0; g < 2; g++) begin
            sb_push(32'hA000_0000, 1'b0, 4'h7, 2'b01);
            sb_push(32'hB000_0004, 1'b1, 4'h5, 2'b10);
        end
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_grant("s2");
            @(posedge clk); #1; pim_ack = 1'b1;
            @(posedge clk); #1; pim_ack = 1'b0;
            if (g == 3) req = '0;
        end
        check("s2_sb_drained", sb_q.size(), 32'd0);

        // S5: reset while in REQ, then ch0 must win again
        do_reset();
        sb_push(32'hA000_0000, 1'b0, 4'h7, 2'b01);
        req = 2'b01;
        wait_grant("s5_pre");
        @(posedge clk); #1;
        req = '0; sys_rst = 1'b1; pim_ack = 1'b1;
        #1;
        check("s5_req_drop", {31'd0, a_addr_req}, 32'd0);
        check("s5_no_ack_now", {30'd0, a_ch_ack}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("s5_no_ack_rst", {30'd0, a_ch_ack}, 32'd0);
        end
        @(posedge clk); #1; sys_rst = 1'b0; pim_ack = 1'b0;
        sb_push(32'hA000_0000, 1'b0, 4'h7, 2'b01);
        req = 2'b11;
        wait_grant("s5_post");

        // S4: owner pops pass on pi_enable, non-owner pops are blocked and flag Err
        @(posedge clk); #1; req = '0; rd_pop = 2'b01;
        repeat (2) begin
            @(negedge clk);
            check("s4_owner_pop", {31'd0, a_rd_pop}, {31'd0, pi_model(2)});
            check("s4_err_clean", {31'd0, a_err}, 32'd0);
            @(posedge clk); #1;
        end
        rd_pop = 2'b10;
        repeat (2) begin
            @(negedge clk);
            check("s4_pop_blocked", {31'd0, a_rd_pop}, 32'd0);
            @(posedge clk); #1;
        end
        rd_pop = '0;
        repeat (3) begin
            @(negedge clk);
            check("s4_err_sticky", {31'd0, a_err}, 32'd1);
        end
        do_reset();
        @(negedge clk);
        check("s4_err_cleared", {31'd0, a_err}, 32'd0);

        // S3: ratio 4, owner ch0 pushes for 3 slow cycles
        n = 0;
        while ((cyc % 4) != 0 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        wr_push = 2'b01;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("s3_push_phase", {31'd0, b_wr_push}, {31'd0, (cyc % 4) == 0});
            if (b_wr_push) pulses++;
            @(posedge clk); #1;
        end
        wr_push = '0;
        check("s3_pulse_count", pulses, 32'd3);
        check("s3_no_err", {31'd0, b_err}, 32'd0);

        // S6: ratio 1, next-cycle grant then qualification table with ch1 as owner
        do_reset();
        req = 2'b10;
        @(negedge clk);
        check("s6_not_yet", {31'd0, c_addr_req}, 32'd0);
        @(posedge clk); #1; req = '0;
        @(negedge clk);
        check("s6_grant_next", {31'd0, c_addr_req}, 32'd1);
        check("s6_owner", {30'd0, c_owner}, 32'd2);
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            rd_pop = vt[v].rd; wr_push = vt[v].wr;
            @(negedge clk);
            check($sformatf("s6_pop_v%0d", v),  {31'd0, c_rd_pop},  {31'd0, vt[v].pop});
            check($sformatf("s6_push_v%0d", v), {31'd0, c_wr_push}, {31'd0, vt[v].push});
            check($sformatf("s6_err_v%0d", v),  {31'd0, c_err},     {31'd0, vt[v].err});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
